purse_controller: RTL and testbench
===================================

Name: purse_controller

Overview:
- Owns the player's money and purse level during a battle.
- Accrues periodic income, saturates money at the level's cap, and arbitrates unit-deploy purchases and purse upgrades against the balance.
- Holds the army cost, upgrade cost and max-money tables internally, and answers single-cycle requests from the deploy/UI logic with registered accept/deny responses.
- Drives money and level to the HUD and the deploy panel.

Parameters:
- TICK_DIV, 10000000: clk cycles per income tick (100 MHz → 10 ticks/s); minimum 2.
- INC_STEP, 1: income per tick per level step; income = (level+1)*INC_STEP.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  battle running; gates income accrual
- clear  input  1  synchronous new-battle clear; same effect as rst, lower priority than rst
- buy_req  input  1  single-cycle deploy request
- buy_kind  input  3  army kind 0..7 for buy_req
- upg_req  input  1  single-cycle purse-upgrade request
- money  output  15  current balance, 0..10000
- level  output  3  purse level 0..7
- max_money  output  15  cap for current level
- buy_ack  output  1  one-cycle pulse answering buy_req
- buy_ok  output  1  valid with buy_ack; 1 = purchased
- upg_ack  output  1  one-cycle pulse answering upg_req
- upg_ok  output  1  valid with upg_ack; 1 = upgraded

Behaviour:
- Reset (rst async, or clear at the edge): money=0, level=0, tick counter=0, all ack/ok outputs=0. max_money follows level, so it is 100 after reset.
- Army cost by kind 0..7: 75, 150, 240, 350, 750, 1500, 2000, 2400.
- Upgrade cost by current level 0..6: 100, 200, 400, 600, 1000, 2000, 4000.
- Max money by level 0..7: 100, 300, 500, 1000, 2000, 4000, 6000, 10000.
- Tick counter:
  - Counts 0..TICK_DIV-1 while en=1 and holds its value while en=0.
  - tick is asserted in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Requests are sampled at a rising edge. The balance update and the ack/ok pulses appear together after that same edge (latency 1). Acks are high for exactly one cycle.
- Priority at one edge: buy before upgrade.
  - If buy_req and upg_req are both high, the buy is evaluated first.
  - The upgrade then gets upg_ack=1 with upg_ok=0, regardless of the balance.
- Buy accept condition: money >= cost(buy_kind).
  - Accepted: money -= cost.
  - Rejected: money unchanged, buy_ok=0.
- Upgrade accept condition: level < 7 and money >= upgcost(level).
  - Accepted: money -= upgcost, level += 1.
  - At level 7: always rejected, and level does not wrap.
- Requests are honoured even when en=0; only income is gated.
- Next-balance arithmetic, computed in 16 bits: next = money - spend + (tick ? income : 0), then saturated to max_money(next level).
  - spend is 0 or the accepted cost; never underflows, because acceptance checks the pre-tick balance.
  - When a tick coincides with an accepted purchase, both apply in the same cycle.
- Saturation: money never exceeds max_money. At the cap, ticks leave money unchanged.
- A request arriving with rst asserted is dropped, and no ack is produced. A request arriving with clear asserted gets ack=1, ok=0.
- Upgrade does not reset the tick counter.

Test Plan (TICK_DIV=4, INC_STEP=1):
1. Reset and accrual: rst pulse, then en=1 for 200 cycles → money=50, level=0, max_money=100. Continue 400 more cycles → money saturates at 100 and stays there.
2. Purchase: with money=100, buy_req with kind 0 → next cycle buy_ack=1, buy_ok=1, money=25. Then buy kind 1 (cost 150) → buy_ok=0, money stays 25.
3. Upgrade: with money=100 at level 0, upg_req → upg_ok=1, level=1, money=0, max_money=300. Then accrue to 300 → money holds at 300.
4. Simultaneous requests: with money=100, level=0, buy_req kind 0 and upg_req in the same cycle → buy_ok=1, upg_ack=1, upg_ok=0, money=25, level=0.
5. Tick plus buy at the same edge: money=80, level=0, buy kind 0 issued on the counter's terminal cycle → money=6 (80-75+1).
6. Ceiling and clear: force level 7 via repeated upgrades, then upg_req with money=10000 → upg_ok=0, level=7, money=10000. Assert clear for 1 cycle → money=0, level=0, and no ack pulses.

Source files
------------

// File: rtl/purse_controller.sv
// -----------------------------------------------------------------------------
// purse_controller
//   Owns the player's balance and purse level during a battle. Income accrues
//   once per TICK_DIV cycles while the battle runs, the balance is clamped to
//   the cap of the current purse level, and single-cycle deploy/upgrade
//   requests are answered one cycle later with registered ack/ok pulses.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         battle running; gates income accrual only
//   clear      synchronous new-battle clear (same effect as rst, lower priority)
//   buy_req    single-cycle deploy request, army kind on buy_kind
//   buy_kind   army kind 0..7
//   upg_req    single-cycle purse-upgrade request
//   money      current balance 0..10000
//   level      purse level 0..7
//   max_money  balance cap for the current level
//   buy_ack    one-cycle pulse answering buy_req; buy_ok = purchased
//   upg_ack    one-cycle pulse answering upg_req; upg_ok = upgraded
// -----------------------------------------------------------------------------
module purse_controller #(
  parameter int TICK_DIV = 10000000,
  parameter int INC_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic        buy_req,
  input  logic [2:0]  buy_kind,
  input  logic        upg_req,
  output logic [14:0] money,
  output logic [2:0]  level,
  output logic [14:0] max_money,
  output logic        buy_ack,
  output logic        buy_ok,
  output logic        upg_ack,
  output logic        upg_ok
);

  localparam int              CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [15:0]      INC_W     = 16'(INC_STEP);

  // Deploy price of each army kind.
  function automatic logic [14:0] army_cost(input logic [2:0] kind);
    case (kind)
      3'd0:    army_cost = 15'd75;
      3'd1:    army_cost = 15'd150;
      3'd2:    army_cost = 15'd240;
      3'd3:    army_cost = 15'd350;
      3'd4:    army_cost = 15'd750;
      3'd5:    army_cost = 15'd1500;
      3'd6:    army_cost = 15'd2000;
      3'd7:    army_cost = 15'd2400;
      default: army_cost = 15'd2400;
    endcase
  endfunction

  // Price of leaving the given level; level 7 is never upgradable.
  function automatic logic [14:0] upg_cost(input logic [2:0] lvl);
    case (lvl)
      3'd0:    upg_cost = 15'd100;
      3'd1:    upg_cost = 15'd200;
      3'd2:    upg_cost = 15'd400;
      3'd3:    upg_cost = 15'd600;
      3'd4:    upg_cost = 15'd1000;
      3'd5:    upg_cost = 15'd2000;
      3'd6:    upg_cost = 15'd4000;
      default: upg_cost = 15'd0;
    endcase
  endfunction

  // Balance cap of each purse level.
  function automatic logic [14:0] level_cap(input logic [2:0] lvl);
    case (lvl)
      3'd0:    level_cap = 15'd100;
      3'd1:    level_cap = 15'd300;
      3'd2:    level_cap = 15'd500;
      3'd3:    level_cap = 15'd1000;
      3'd4:    level_cap = 15'd2000;
      3'd5:    level_cap = 15'd4000;
      3'd6:    level_cap = 15'd6000;
      3'd7:    level_cap = 15'd10000;
      default: level_cap = 15'd10000;
    endcase
  endfunction

  logic [CNT_W-1:0] tick_cnt_r;
  logic [14:0]      money_r;
  logic [2:0]       level_r;
  logic [14:0]      max_money_r;
  logic             buy_ack_r;
  logic             buy_ok_r;
  logic             upg_ack_r;
  logic             upg_ok_r;

  logic             tick_s;
  logic [14:0]      buy_cost_s;
  logic [14:0]      upg_cost_s;
  logic             buy_ok_s;
  logic             upg_ok_s;
  logic [15:0]      spend_s;
  logic [15:0]      income_s;
  logic [15:0]      sum_s;
  logic [2:0]       level_nx_s;
  logic [14:0]      cap_nx_s;
  logic [14:0]      money_nx_s;

  // Income tick: the counter only advances while the battle runs.
  always_comb begin
    tick_s = en && (tick_cnt_r == TICK_LAST);
  end

  // Request arbitration and next-balance computation.
  always_comb begin
    buy_cost_s = army_cost(buy_kind);
    upg_cost_s = upg_cost(level_r);
    buy_ok_s   = 1'b0;
    upg_ok_s   = 1'b0;
    spend_s    = 16'd0;
    level_nx_s = level_r;
    // A buy always wins the edge; a simultaneous upgrade is acked but refused.
    if (buy_req) begin
      if (money_r >= buy_cost_s) begin
        buy_ok_s = 1'b1;
        spend_s  = {1'b0, buy_cost_s};
      end else begin
        buy_ok_s = 1'b0;
      end
    end else if (upg_req) begin
      if ((level_r != 3'd7) && (money_r >= upg_cost_s)) begin
        upg_ok_s   = 1'b1;
        spend_s    = {1'b0, upg_cost_s};
        level_nx_s = level_r + 3'd1;
      end else begin
        upg_ok_s = 1'b0;
      end
    end else begin
      spend_s = 16'd0;
    end
    // Income uses the level in force before this edge's upgrade.
    if (tick_s) begin
      income_s = ({13'd0, level_r} + 16'd1) * INC_W;
    end else begin
      income_s = 16'd0;
    end
    // Acceptance was checked against the pre-tick balance, so no underflow.
    sum_s    = {1'b0, money_r} - spend_s + income_s;
    cap_nx_s = level_cap(level_nx_s);
    if (sum_s > {1'b0, cap_nx_s}) begin
      money_nx_s = cap_nx_s;
    end else begin
      money_nx_s = sum_s[14:0];
    end
  end

  // State and registered responses; clear acks requests but refuses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r  <= '0;
      money_r     <= 15'd0;
      level_r     <= 3'd0;
      max_money_r <= 15'd100;
      buy_ack_r   <= 1'b0;
      buy_ok_r    <= 1'b0;
      upg_ack_r   <= 1'b0;
      upg_ok_r    <= 1'b0;
    end else if (clear) begin
      tick_cnt_r  <= '0;
      money_r     <= 15'd0;
      level_r     <= 3'd0;
      max_money_r <= 15'd100;
      buy_ack_r   <= buy_req;
      buy_ok_r    <= 1'b0;
      upg_ack_r   <= upg_req;
      upg_ok_r    <= 1'b0;
    end else begin
      if (tick_s) begin
        tick_cnt_r <= '0;
      end else if (en) begin
        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
      money_r     <= money_nx_s;
      level_r     <= level_nx_s;
      max_money_r <= cap_nx_s;
      buy_ack_r   <= buy_req;
      buy_ok_r    <= buy_ok_s;
      upg_ack_r   <= upg_req;
      upg_ok_r    <= upg_ok_s;
    end
  end

  assign money     = money_r;
  assign level     = level_r;
  assign max_money = max_money_r;
  assign buy_ack   = buy_ack_r;
  assign buy_ok    = buy_ok_r;
  assign upg_ack   = upg_ack_r;
  assign upg_ok    = upg_ok_r;

endmodule

// File: tb/tb_purse_controller.sv
module tb_purse_controller;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        en       = 1'b0;
  logic        clear    = 1'b0;
  logic        buy_req  = 1'b0;
  logic [2:0]  buy_kind = 3'd0;
  logic        upg_req  = 1'b0;
  logic [14:0] money;
  logic [2:0]  level;
  logic [14:0] max_money;
  logic        buy_ack;
  logic        buy_ok;
  logic        upg_ack;
  logic        upg_ok;

  purse_controller #(.TICK_DIV(4), .INC_STEP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .buy_req(buy_req), .buy_kind(buy_kind), .upg_req(upg_req),
    .money(money), .level(level), .max_money(max_money),
    .buy_ack(buy_ack), .buy_ok(buy_ok), .upg_ack(upg_ack), .upg_ok(upg_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ba;
    logic        bo;
    logic        ua;
    logic        uo;
    logic [14:0] money;
    logic [2:0]  level;
    logic [14:0] maxm;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;
  logic probe  = 1'b0;
  logic done   = 1'b0;

  // Hand tables from the purse definition.
  int cap_t [0:7] = '{100, 300, 500, 1000, 2000, 4000, 6000, 10000};
  int upg_t [0:6] = '{100, 200, 400, 600, 1000, 2000, 4000};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input bit ba, input bit bo, input bit ua,
                      input bit uo, input int m, input int lv, input int mx);
    exp_t e;
    e.name  = nm;
    e.ba    = ba;
    e.bo    = bo;
    e.ua    = ua;
    e.uo    = uo;
    e.money = 15'(m);
    e.level = 3'(lv);
    e.maxm  = 15'(mx);
    exp_q.push_back(e);
  endtask

  // Ask the monitor to compare the idle state (no acks) at the next negedge.
  task automatic probe_state(input string nm, input int m, input int lv, input int mx);
    push(nm, 1'b0, 1'b0, 1'b0, 1'b0, m, lv, mx);
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  // Issue a one-cycle request; the response is expected after the sampling edge.
  task automatic request(input string nm, input bit b, input int k, input bit u,
                         input bit ba, input bit bo, input bit ua, input bit uo,
                         input int m, input int lv, input int mx);
    push(nm, ba, bo, ua, uo, m, lv, mx);
    buy_req  = b;
    buy_kind = 3'(k);
    upg_req  = u;
    step(1);
    buy_req = 1'b0;
    upg_req = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per response or probe and compares it.
  always @(negedge clk) begin
    cycles = cycles + 1;
    if (cycles > 60000) begin
      $display("FAIL watchdog: cycle budget exceeded, %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog");
    end
    if (buy_ack || upg_ack || probe) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_ack: got buy_ack=%0b upg_ack=%0b, required no response",
                 buy_ack, upg_ack);
      end else begin
        cur_e = exp_q.pop_front();
        if (buy_ack !== cur_e.ba || buy_ok !== cur_e.bo || upg_ack !== cur_e.ua ||
            upg_ok !== cur_e.uo || money !== cur_e.money || level !== cur_e.level ||
            max_money !== cur_e.maxm) begin
          errors = errors + 1;
          $display("FAIL %s: got ba=%0b bo=%0b ua=%0b uo=%0b money=%0d level=%0d max=%0d, required ba=%0b bo=%0b ua=%0b uo=%0b money=%0d level=%0d max=%0d",
                   cur_e.name, buy_ack, buy_ok, upg_ack, upg_ok, money, level, max_money,
                   cur_e.ba, cur_e.bo, cur_e.ua, cur_e.uo, cur_e.money, cur_e.level, cur_e.maxm);
        end
      end
    end
    if (done) begin
      checks = checks + 1;
      if (exp_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL pending_responses: got %0d unanswered expectations, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    probe_state("reset", 0, 0, 100);

    // Accrual and saturation at level 0.
    en = 1'b1; step(200); en = 1'b0;
    probe_state("accrue_200", 50, 0, 100);
    en = 1'b1; step(400); en = 1'b0;
    probe_state("saturate_100", 100, 0, 100);

    // Purchases: affordable, then unaffordable.
    request("buy_k0", 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 25, 0, 100);
    request("buy_k1_poor", 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 25, 0, 100);

    // Upgrade at exactly the cost, then accrue to the new cap.
    en = 1'b1; step(400); en = 1'b0;
    probe_state("refill_100", 100, 0, 100);
    request("upg_l0", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 300);
    en = 1'b1; step(800); en = 1'b0;
    probe_state("cap_300", 300, 1, 300);

    // Clear without requests, then simultaneous buy + upgrade.
    clear = 1'b1; step(1); clear = 1'b0;
    probe_state("clear_idle", 0, 0, 100);
    en = 1'b1; step(400); en = 1'b0;
    probe_state("refill_after_clear", 100, 0, 100);
    request("buy_and_upg", 1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 25, 0, 100);

    // Tick and buy on the same edge: counter is 0 here, 220 edges give 55 ticks.
    en = 1'b1; step(220); en = 1'b0;
    probe_state("pre_tick_80", 80, 0, 100);
    en = 1'b1; step(3);
    request("tick_buy", 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6, 0, 100);
    en = 1'b0;

    // Climb to level 7, filling to each cap before upgrading.
    for (int lv = 0; lv < 7; lv++) begin
      en = 1'b1; step(4 * (cap_t[lv] / (lv + 1) + 2)); en = 1'b0;
      probe_state($sformatf("full_l%0d", lv), cap_t[lv], lv, cap_t[lv]);
      request($sformatf("upg_l%0d", lv), 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              cap_t[lv] - upg_t[lv], lv + 1, cap_t[lv + 1]);
    end
    en = 1'b1; step(4 * (10000 / 8 + 2)); en = 1'b0;
    probe_state("full_l7", 10000, 7, 10000);
    request("upg_l7_ceiling", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10000, 7, 10000);
    request("buy_k7", 1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7600, 7, 10000);

    clear = 1'b1; step(1); clear = 1'b0;
    probe_state("clear_l7", 0, 0, 100);

    // Requests during clear are acked but refused.
    en = 1'b1; step(400); en = 1'b0;
    probe_state("refill_final", 100, 0, 100);
    clear = 1'b1;
    request("req_with_clear", 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 100);
    clear = 1'b0;

    // Requests during rst are dropped without an ack.
    en = 1'b1; step(40); en = 1'b0;
    rst = 1'b1; buy_req = 1'b1; upg_req = 1'b1;
    step(1);
    rst = 1'b0; buy_req = 1'b0; upg_req = 1'b0;
    step(1);
    probe_state("rst_drop", 0, 0, 100);

    step(2);
    done = 1'b1;
    step(4);
  end

endmodule
